adder_16bit_arbiter: RTL and testbench
======================================

# adder_16bit_arbiter

Round-robin arbiter and scheduler that shares one `adder_16bit` datapath between `NUM_REQ` independent requesters. Each requester presents operands over a valid/ready handshake. The block selects one winner per cycle, drives the shared adder, and registers the sum, carry, overflow and the winner's ID into a single-entry output stage with its own valid/ready handshake. It sits between the requesting engines and the shared adder and owns all sequencing of that adder.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2–8.
- `WIDTH`, default 16: operand width; passed through to the `adder_16bit` instance.
- `ID_W`, default `$clog2(NUM_REQ)`: width of `res_id`.

Ports:
- `clk`  in  1  single clock; all state on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester operand valid.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- `req_a`  in  NUM_REQ*WIDTH  packed operand A; requester i occupies `[i*WIDTH +: WIDTH]`.
- `req_b`  in  NUM_REQ*WIDTH  packed operand B, same packing as `req_a`.
- `req_cin`  in  NUM_REQ  per-requester carry-in.
- `res_valid`  out  1  output register holds a result.
- `res_ready`  in  1  consumer accepts the result.
- `res_sum`  out  WIDTH  registered sum.
- `res_cout`  out  1  registered carry-out.
- `res_overflow`  out  1  registered signed overflow.
- `res_id`  out  ID_W  index of the requester that produced the result.
- `ovf_sticky`  out  NUM_REQ  per-requester sticky signed-overflow flag.
- `ovf_clr`  in  NUM_REQ  clears the matching `ovf_sticky` bit.
- `op_count`  out  32  total accepted operations; saturates at 0xFFFF_FFFF.

## Operation
- Output stage is a two-state FSM:
  - EMPTY: `res_valid`=0.
  - FULL: `res_valid`=1.
- `can_accept` = EMPTY, or (FULL and `res_ready`). This allows a full-throughput drain-and-refill in the same cycle.
- Arbitration:
  - Round-robin pointer `ptr` (ID_W bits) gives highest priority to requester `ptr`, then `ptr+1`, and so on, wrapping modulo NUM_REQ.
  - The winner is the first requester in that order with `req_valid`=1.
  - `req_ready[win]` = `can_accept`; all other `req_ready` bits are 0.
  - `req_ready` may depend on `req_valid`; `req_valid` must not depend on `req_ready`.
- On handshake (`req_valid[i]` & `req_ready[i]`):
  - `req_a`/`req_b`/`req_cin` slice i is muxed into the combinational `adder_16bit`.
  - Sum, carry, overflow and `i` are registered into the output stage; the FSM goes to FULL.
  - `ptr` advances to `(i+1) mod NUM_REQ`.
  - `op_count` increments unless already saturated.
  - `ovf_sticky[i]` is set if the adder's overflow output is 1.
- The pointer does not move when no request is accepted.
- FULL and `res_ready`=1 with no new accept: go to EMPTY. Output data fields hold their last values; `res_valid` drops.
- FULL and `res_ready`=0: every output field holds stable and all `req_ready` bits are 0.
- `ovf_clr[i]` and a same-cycle set of bit i: set wins, and the bit stays 1.
- Arithmetic: `res_sum` = (a + b + cin) mod 2^WIDTH. `res_cout` = bit WIDTH of that sum. `res_overflow` = (a[MSB] == b[MSB]) & (sum[MSB] != a[MSB]).
- Reset, asynchronous on falling `rst`, applies mid-transfer as well: a result in flight is discarded. Reset values:
  - state = EMPTY.
  - `res_valid`, `res_sum`, `res_cout`, `res_overflow`, `res_id` = 0.
  - `ptr` = 0.
  - `op_count` = 0.
  - `ovf_sticky` = 0.
  - `req_ready` = 0 while `rst`=0.

## Timing
- Latency: handshake at edge N puts `res_valid`=1 with the result during cycle N+1.
- Throughput: one operation per cycle while `res_ready` stays high.
- All `res_*` outputs come straight from flops.
- `req_ready` is combinational from `req_valid`, `ptr`, state and `res_ready`.
- `op_count` and `ovf_sticky` update on the same edge as the accept.
- Reset deassertion is synchronous to `clk` at the system level. The first accept is possible on the first edge after `rst` rises.

## Test plan
- **Single op:** requester 2 presents a=0x1234, b=0x4321, cin=0. Required: `req_ready[2]`=1 that cycle. Next cycle `res_valid`=1, `res_sum`=0x5555, `res_cout`=0, `res_overflow`=0, `res_id`=2, `op_count`=1.
- **Arithmetic corners:**
  - a=0x7FFF, b=0x0001 gives sum 0x8000, overflow=1, cout=0, and sets `ovf_sticky[id]`.
  - a=0xFFFF, b=0x0000, cin=1 gives sum 0x0000, cout=1, overflow=0.
  - a=0x8000, b=0x8000 gives sum 0x0000, cout=1, overflow=1.
- **Fairness:** all four requesters valid continuously with `res_ready`=1 from reset. Required: `res_id` sequence 0,1,2,3,0,1… with one result per cycle and no gaps.
- **Backpressure:** hold `res_ready`=0 for 5 cycles while requesters 1 and 3 are valid. Required: result held stable, all `req_ready`=0, `ptr` frozen. On release, drain and refill occur in the same cycle.
- **Sticky clear race:** assert `ovf_clr[0]` on the same edge that an overflowing op from requester 0 is accepted. Required: `ovf_sticky[0]` remains 1. A lone `ovf_clr[0]` a cycle later clears it to 0.
- **Reset mid-operation:** drop `rst` while FULL with `res_ready`=0. Required: immediately `res_valid`=0, all outputs 0, `op_count`=0. After release, the first grant goes to requester 0 when all are valid.

Source files
------------

// File: rtl/adder_16bit_arbiter.sv
// Round-robin scheduler sharing one combinational adder between NUM_REQ requesters,
// with a single-entry registered result stage and per-requester sticky overflow flags.

module adder_16bit #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    logic [WIDTH:0] total;

    assign total    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sum      = total[WIDTH-1:0];
    assign cout     = total[WIDTH];
    assign overflow = (a[WIDTH-1] == b[WIDTH-1]) && (total[WIDTH-1] != a[WIDTH-1]);
endmodule

module adder_16bit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_sum,
    output logic                     res_cout,
    output logic                     res_overflow,
    output logic [ID_W-1:0]          res_id,
    output logic [NUM_REQ-1:0]       ovf_sticky,
    input  logic [NUM_REQ-1:0]       ovf_clr,
    output logic [31:0]              op_count
);
    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    state_t              state_reg, state_next;
    logic [ID_W-1:0]     ptr_reg, ptr_next;
    logic [WIDTH-1:0]    sum_reg;
    logic                cout_reg;
    logic                ovf_reg;
    logic [ID_W-1:0]     id_reg;
    logic [31:0]         count_reg;
    logic [NUM_REQ-1:0]  sticky_reg;

    logic                can_accept;
    logic                win_found;
    logic [ID_W-1:0]     win_idx;
    logic                accept;
    logic [ID_W:0]       scan_idx;

    logic [WIDTH-1:0]    a_sel, b_sel;
    logic                cin_sel;
    logic [WIDTH-1:0]    add_sum;
    logic                add_cout, add_ovf;

    assign can_accept = (state_reg == ST_EMPTY) || res_ready;

    // Scan from ptr upward, wrapping; one extra index bit avoids overflow before the wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, ptr_reg} + (ID_W+1)'(k);
            if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
            end
            if (!win_found && req_valid[scan_idx[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[ID_W-1:0];
            end
        end
    end

    // Gating with rst keeps every grant low while reset is held.
    assign accept = win_found && can_accept && rst;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = accept && (win_idx == ID_W'(gi));
        end
    endgenerate

    assign a_sel   = req_a[win_idx*WIDTH +: WIDTH];
    assign b_sel   = req_b[win_idx*WIDTH +: WIDTH];
    assign cin_sel = req_cin[win_idx];

    adder_16bit #(
        .WIDTH(WIDTH)
    ) u_adder (
        .a       (a_sel),
        .b       (b_sel),
        .cin     (cin_sel),
        .sum     (add_sum),
        .cout    (add_cout),
        .overflow(add_ovf)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (accept) state_next = ST_FULL;
            end
            ST_FULL: begin
                if (accept)         state_next = ST_FULL;
                else if (res_ready) state_next = ST_EMPTY;
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    assign ptr_next = (win_idx == ID_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_EMPTY;
            ptr_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            id_reg    <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                ptr_reg  <= ptr_next;
                sum_reg  <= add_sum;
                cout_reg <= add_cout;
                ovf_reg  <= add_ovf;
                id_reg   <= win_idx;
                if (count_reg != 32'hFFFF_FFFF) count_reg <= count_reg + 32'd1;
            end
        end
    end

    // A same-edge set beats a clear so an overflow is never lost.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sticky
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sticky_reg[gi] <= 1'b0;
                end else if (accept && (win_idx == ID_W'(gi)) && add_ovf) begin
                    sticky_reg[gi] <= 1'b1;
                end else if (ovf_clr[gi]) begin
                    sticky_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign res_valid    = (state_reg == ST_FULL);
    assign res_sum      = sum_reg;
    assign res_cout     = cout_reg;
    assign res_overflow = ovf_reg;
    assign res_id       = id_reg;
    assign op_count     = count_reg;
    assign ovf_sticky   = sticky_reg;
endmodule

// File: tb/tb_adder_16bit_arbiter.sv
// Scoreboard bench: a reference model predicts grants and results from the arbitration
// rules and queues them; an independent monitor compares what the result stage presents.

module tb_adder_16bit_arbiter;
    localparam int N = 4;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a, req_b;
    logic [N-1:0]   req_cin;
    logic           res_valid, res_ready;
    logic [W-1:0]   res_sum;
    logic           res_cout, res_overflow;
    logic [1:0]     res_id;
    logic [N-1:0]   ovf_sticky, ovf_clr;
    logic [31:0]    op_count;

    always #5 clk = ~clk;

    adder_16bit_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_cout(res_cout), .res_overflow(res_overflow),
        .res_id(res_id), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr),
        .op_count(op_count)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           id;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    int          m_ptr = 0;
    bit          m_full = 0;
    logic [31:0] m_count = 0;
    logic [N-1:0] m_sticky = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = c;
    endtask

    // Reference model: grant, result prediction, counters and sticky flags.
    initial forever begin
        int           win;
        int           j;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] set_bits;
        logic [W-1:0] a, b;
        logic [W:0]   total;
        exp_t         e;
        @(negedge clk);
        if (!rst) begin
            chk("ready_in_reset", {28'd0, req_ready}, 32'd0);
            m_ptr = 0; m_full = 0; m_count = 0; m_sticky = '0;
            q.delete();
        end else begin
            chk("res_valid", {31'd0, res_valid}, {31'd0, m_full});
            chk("op_count", op_count, m_count);
            chk("ovf_sticky", {28'd0, ovf_sticky}, {28'd0, m_sticky});
            win = -1;
            exp_rdy = '0;
            if (!m_full || res_ready) begin
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (win < 0 && req_valid[j]) win = j;
                end
            end
            if (win >= 0) exp_rdy[win] = 1'b1;
            chk("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
            set_bits = '0;
            if (win >= 0) begin
                a = req_a[win*W +: W];
                b = req_b[win*W +: W];
                total = a + b + req_cin[win];
                e.sum  = total[W-1:0];
                e.cout = total[W];
                e.ovf  = (a[W-1] == b[W-1]) && (total[W-1] != a[W-1]);
                e.id   = win;
                q.push_back(e);
                m_ptr = (win + 1) % N;
                if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
                if (e.ovf) set_bits[win] = 1'b1;
            end
            m_sticky = (m_sticky & ~ovf_clr) | set_bits;
            m_full = (win >= 0) ? 1'b1 : ((m_full && res_ready) ? 1'b0 : m_full);
        end
    end

    // Monitor: whatever the result stage holds must match the oldest prediction.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst && res_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual id=%0d sum=%h required=none", res_id, res_sum);
            end else begin
                e = q[0];
                chk("res_sum", {16'd0, res_sum}, {16'd0, e.sum});
                chk("res_cout", {31'd0, res_cout}, {31'd0, e.cout});
                chk("res_overflow", {31'd0, res_overflow}, {31'd0, e.ovf});
                chk("res_id", {30'd0, res_id}, e.id);
                $display("RES id=%0d sum=%h cout=%0d ovf=%0d taken=%0d",
                         res_id, res_sum, res_cout, res_overflow, res_ready);
                if (res_ready) e = q.pop_front();
            end
        end
    end

    initial begin
        logic [W-1:0] held_sum;
        req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;
        res_ready = 1'b1; ovf_clr = '0;
        repeat (2) @(posedge clk);
        #1;
        req_valid = '1;
        #1;
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_sum", {16'd0, res_sum}, 32'd0);
        chk("rst_res_cout_ovf", {30'd0, res_cout, res_overflow}, 32'd0);
        chk("rst_res_id", {30'd0, res_id}, 32'd0);
        chk("rst_op_count", op_count, 32'd0);
        chk("rst_sticky", {28'd0, ovf_sticky}, 32'd0);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        req_valid = '0;
        rst = 1'b1;

        // single op from requester 2
        set_op(2, 16'h1234, 16'h4321, 1'b0);
        req_valid = 4'b0100;
        #1 chk("single_ready", {28'd0, req_ready}, 32'h4);
        tick();
        req_valid = '0;
        chk("single_sum", {16'd0, res_sum}, 32'h5555);
        chk("single_id", {30'd0, res_id}, 32'd2);
        chk("single_count", op_count, 32'd1);

        // arithmetic corners
        set_op(1, 16'h7FFF, 16'h0001, 1'b0); req_valid = 4'b0010; tick();
        chk("corner_7fff_sum", {15'd0, res_cout, res_overflow, res_sum}, {15'd0, 2'b01, 16'h8000});
        set_op(3, 16'hFFFF, 16'h0000, 1'b1); req_valid = 4'b1000; tick();
        chk("corner_ffff_sum", {15'd0, res_cout, res_overflow, res_sum}, {15'd0, 2'b10, 16'h0000});
        set_op(0, 16'h8000, 16'h8000, 1'b0); req_valid = 4'b0001; tick();
        chk("corner_8000_sum", {15'd0, res_cout, res_overflow, res_sum}, {15'd0, 2'b11, 16'h0000});
        req_valid = '0; tick();
        chk("corner_sticky", {28'd0, ovf_sticky}, 32'h3);
        ovf_clr = '1; tick(); ovf_clr = '0;

        // fairness from reset
        rst = 1'b0; tick();
        req_valid = '1; rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom), 1'($urandom));
            tick();
            chk("fair_id", {30'd0, res_id}, k % N);
            chk("fair_valid", {31'd0, res_valid}, 32'd1);
        end

        // backpressure with requesters 1 and 3
        req_valid = 4'b1010; res_ready = 1'b0;
        held_sum = res_sum;
        repeat (5) tick();
        chk("bp_held_sum", {16'd0, res_sum}, {16'd0, held_sum});
        res_ready = 1'b1;
        repeat (3) tick();

        // sticky clear race on requester 0
        req_valid = '0; tick();
        ovf_clr = '1; tick();
        set_op(0, 16'h7FFF, 16'h0001, 1'b0);
        req_valid = 4'b0001; ovf_clr = 4'b0001; tick();
        chk("race_set_wins", {31'd0, ovf_sticky[0]}, 32'd1);
        req_valid = '0; tick();
        chk("lone_clear", {31'd0, ovf_sticky[0]}, 32'd0);
        ovf_clr = '0;

        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) set_op(i, 16'h7FFF, 16'h0001, 1'($urandom));
                else set_op(i, W'($urandom), W'($urandom), 1'($urandom));
            end
            res_ready = ($urandom_range(0, 3) != 0);
            ovf_clr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            tick();
        end
        ovf_clr = '0;

        // reset while FULL and stalled
        req_valid = 4'b0100; res_ready = 1'b0; tick(); tick();
        #2 rst = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, res_valid}, 32'd0);
        chk("midrst_outputs", {13'd0, res_cout, res_overflow, res_id, res_sum}, 32'd0);
        chk("midrst_count", op_count, 32'd0);
        tick();
        req_valid = '1; res_ready = 1'b1; rst = 1'b1;
        #1 chk("postrst_grant", {28'd0, req_ready}, 32'h1);
        tick();
        chk("postrst_id", {30'd0, res_id}, 32'd0);

        req_valid = '0;
        repeat (3) tick();
        chk("queue_drained", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
